// File: rtl/difftest_intreg_pkg.sv
// Shared widths, FSM state type and snapshot helper for the integer-register
// difftest export scheduler.
package difftest_intreg_pkg;

    localparam int NUM_ARCH_REGS = 32;
    localparam int XLEN          = 64;
    localparam int SNAP_W        = NUM_ARCH_REGS * XLEN;
    localparam int COREID_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } sched_state_e;

    // x0 is hardwired to zero architecturally, whatever the source slice holds.
    function automatic logic [SNAP_W-1:0] clear_reg0(input logic [SNAP_W-1:0] snap);
        logic [SNAP_W-1:0] res;
        res           = snap;
        res[XLEN-1:0] = '0;
        return res;
    endfunction

endpackage

// File: rtl/difftest_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// ptr, wrapping at N.
module difftest_rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N)) begin
                sum = sum - (IDX_W + 1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/difftest_intreg_sched.sv
// Round-robin scheduler exporting per-core integer-register snapshots onto one
// DiffExt port. Optional counters: define DIFFTEST_INTREG_STATS_EN.
module difftest_intreg_sched
    import difftest_intreg_pkg::*;
#(
    parameter int NUM_CORES    = 2,
    parameter int MIN_GAP      = 0,
    parameter int CORE_ID_BASE = 0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_CORES-1:0]        req_valid,
    output logic [NUM_CORES-1:0]        req_ready,
    input  logic [NUM_CORES*SNAP_W-1:0] req_value,
    output logic                        out_enable,
    output logic [SNAP_W-1:0]           out_value,
    output logic [COREID_W-1:0]         out_coreid
`ifdef DIFFTEST_INTREG_STATS_EN
    ,
    output logic [31:0]                 stat_exports,
    output logic [31:0]                 stat_stalls
`endif
);

    localparam int               PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_CORES - 1);
    localparam logic [7:0]       GAP_INIT = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

    sched_state_e        state_q, state_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [7:0]          gap_q;
    logic [SNAP_W-1:0]   hold_q;
    logic [COREID_W-1:0] coreid_q;
    logic [NUM_CORES-1:0] grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                accept;

    difftest_rr_arbiter #(
        .N(NUM_CORES)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr_q),
        .enable   (state_q == IDLE),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_d   = EMIT;
                end
            end
            EMIT:    state_d = (MIN_GAP > 0) ? GAP : IDLE;
            GAP:     if (gap_q == 8'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= PTR_RST;
            gap_q    <= 8'd0;
            // NOTE: the wide snapshot buffer is reset deliberately: out_value must read
            // zero after reset and a snapshot held across reset must never surface.
            hold_q   <= '0;
            coreid_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                hold_q   <= clear_reg0(req_value[int'(grant_idx)*SNAP_W +: SNAP_W]);
                coreid_q <= COREID_W'(grant_idx) + COREID_W'(CORE_ID_BASE);
                ptr_q    <= grant_idx;
            end
            if (state_q == EMIT) begin
                gap_q <= GAP_INIT;
            end else if (state_q == GAP && gap_q != 8'd0) begin
                gap_q <= gap_q - 8'd1;
            end
        end
    end

    assign out_enable = (state_q == EMIT);
    assign out_value  = hold_q;
    assign out_coreid = coreid_q;

`ifdef DIFFTEST_INTREG_STATS_EN
    // A stall is any cycle in which some valid requester is left unaccepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_exports <= 32'd0;
            stat_stalls  <= 32'd0;
        end else begin
            if (state_q == EMIT && stat_exports != 32'hFFFF_FFFF) begin
                stat_exports <= stat_exports + 32'd1;
            end
            if (|(req_valid & ~req_ready) && stat_stalls != 32'hFFFF_FFFF) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
